// File: rtl/iobs_pkg.sv
// Shared types and defaults for the I/O bus sequencer.
package iobs_pkg;

    // Sequencer states: idle, wait for a buffered write to drain, launch,
    // wait for completion, hold the result until the CPU cycle ends.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUFW   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } iobs_state_e;

    // Default number of FCLK cycles an I/O cycle may wait for IODONE.
    localparam logic [7:0] IOBS_TIMEOUT_DEFAULT = 8'd200;

    // A write to a posting-eligible address completes to the CPU at once.
    function automatic logic is_posted(input logic n_we, input logic pwcs);
        return ~n_we & pwcs;
    endfunction

endpackage

// File: rtl/iobs_if.sv
// FSB-side and I/O-master-side handshake signals of the I/O bus sequencer.
interface iobs_if;
    logic BACT;
    logic IOCS;
    logic IOPWCS;
    logic nWE;
    logic IOACT;
    logic IODONE;
    logic IOBERR;
    logic IOREQ;
    logic IOWR;
    logic ALE;
    logic Ready1;
    logic BERR1;
    logic PWPEND;

    // Environment side: drives the CPU cycle and I/O master responses.
    modport master (
        output BACT, IOCS, IOPWCS, nWE, IOACT, IODONE, IOBERR,
        input  IOREQ, IOWR, ALE, Ready1, BERR1, PWPEND
    );

    // Sequencer side.
    modport slave (
        input  BACT, IOCS, IOPWCS, nWE, IOACT, IODONE, IOBERR,
        output IOREQ, IOWR, ALE, Ready1, BERR1, PWPEND
    );
endinterface

// File: rtl/iobs_wdt.sv
// Watchdog counter bounding how long an I/O cycle may wait for IODONE.
module iobs_wdt
    import iobs_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = IOBS_TIMEOUT_DEFAULT
) (
    input  logic FCLK,
    input  logic nRST,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;
    logic [7:0] count_inc;

    assign count_inc = count_q + 8'd1;

    // Clear wins over counting; hold when neither is requested.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (enable_i) begin
            count_d = count_inc;
        end
    end

    // Counter register.
    always_ff @(posedge FCLK or negedge nRST) begin
        if (!nRST) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flags the edge on which the count reaches TIMEOUT, so the owner can
    // react on that same edge (TIMEOUT edges after counting starts).
    assign expired_o = enable_i & (count_inc == TIMEOUT);

endmodule

// File: rtl/iobs.sv
// I/O bus sequencer: turns FSB cycles decoded to I/O space into requests
// for the I/O bus master, with posted writes and a completion watchdog.
module iobs
    import iobs_pkg::*;
#(
    parameter logic [7:0] TIMEOUT = IOBS_TIMEOUT_DEFAULT
) (
    input logic   FCLK,
    input logic   nRST,
    iobs_if.slave bus
);

    iobs_state_e state_q;
    logic        ioreq_q;
    logic        iowr_q;
    logic        ale_q;
    logic        rdy_q;
    logic        berr_q;
    logic        pwpend_q;

    logic        wdt_clear;
    logic        wdt_enable;
    logic        wdt_expired;
    logic        path_free;
    logic        go_launch;

    // The counter restarts in LAUNCH and runs only while waiting.
    assign wdt_clear  = (state_q == ST_LAUNCH);
    assign wdt_enable = (state_q == ST_WAIT);

    iobs_wdt #(
        .TIMEOUT (TIMEOUT)
    ) u_wdt (
        .FCLK      (FCLK),
        .nRST      (nRST),
        .clear_i   (wdt_clear),
        .enable_i  (wdt_enable),
        .expired_o (wdt_expired)
    );

    // The I/O master can take a new request only when no posted write is
    // outstanding and it is not busy. pwpend_q is the registered flag, so a
    // write that completes this cycle still blocks launch until the next.
    assign path_free = ~pwpend_q & ~bus.IOACT;

    assign go_launch = ((state_q == ST_IDLE) & bus.BACT & bus.IOCS & path_free) |
                       ((state_q == ST_BUFW) & bus.BACT & path_free);

    // Sequencer FSM with registered outputs.
    always_ff @(posedge FCLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= ST_IDLE;
            ioreq_q  <= 1'b0;
            iowr_q   <= 1'b0;
            ale_q    <= 1'b0;
            rdy_q    <= 1'b0;
            berr_q   <= 1'b0;
            pwpend_q <= 1'b0;
        end else begin
            ale_q <= 1'b0;

            // The request is held until the master accepts it.
            if (ioreq_q && bus.IOACT) begin
                ioreq_q <= 1'b0;
            end

            // Completion of a posted write; its error status is dropped.
            if (pwpend_q && bus.IODONE) begin
                pwpend_q <= 1'b0;
            end

            // Entering LAUNCH: latch pulse, request and direction.
            if (go_launch) begin
                ale_q   <= 1'b1;
                ioreq_q <= 1'b1;
                iowr_q  <= ~bus.nWE;
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.BACT && bus.IOCS) begin
                        state_q <= (pwpend_q || bus.IOACT) ? ST_BUFW : ST_LAUNCH;
                    end
                end

                ST_BUFW: begin
                    if (!bus.BACT) begin
                        state_q <= ST_IDLE;
                    end else if (path_free) begin
                        state_q <= ST_LAUNCH;
                    end
                end

                ST_LAUNCH: begin
                    if (is_posted(bus.nWE, bus.IOPWCS)) begin
                        pwpend_q <= 1'b1;
                        rdy_q    <= 1'b1;
                        state_q  <= ST_DONE;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // If the CPU has abandoned the cycle, finish silently.
                    if (bus.IODONE) begin
                        if (bus.BACT) begin
                            if (bus.IOBERR) begin
                                berr_q <= 1'b1;
                            end else begin
                                rdy_q <= 1'b1;
                            end
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (wdt_expired) begin
                        ioreq_q <= 1'b0;
                        if (bus.BACT) begin
                            berr_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end

                ST_DONE: begin
                    if (!bus.BACT) begin
                        rdy_q   <= 1'b0;
                        berr_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Non-I/O cycles are never stalled.
    assign bus.Ready1 = ~bus.IOCS | rdy_q;
    assign bus.IOREQ  = ioreq_q;
    assign bus.IOWR   = iowr_q;
    assign bus.ALE    = ale_q;
    assign bus.BERR1  = berr_q;
    assign bus.PWPEND = pwpend_q;

endmodule

// File: tb/tb_iobs.sv
// Directed bench for the I/O bus sequencer (TIMEOUT = 8).
module tb_iobs;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    iobs_if bus ();

    iobs #(
        .TIMEOUT (8'd8)
    ) dut (
        .FCLK (clk),
        .nRST (rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0b", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cycle(input logic bact, input logic iocs,
                             input logic nwe, input logic pwcs);
        bus.BACT   = bact;
        bus.IOCS   = iocs;
        bus.nWE    = nwe;
        bus.IOPWCS = pwcs;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "bench watchdog");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        bus.IOACT  = 1'b0;
        bus.IODONE = 1'b0;
        bus.IOBERR = 1'b0;
        set_cycle(1'b0, 1'b1, 1'b1, 1'b0);

        // Reset state
        #12;
        check_val("rst_ioreq",  bus.IOREQ,  1'b0);
        check_val("rst_iowr",   bus.IOWR,   1'b0);
        check_val("rst_ale",    bus.ALE,    1'b0);
        check_val("rst_ready1", bus.Ready1, 1'b0);
        check_val("rst_berr1",  bus.BERR1,  1'b0);
        check_val("rst_pwpend", bus.PWPEND, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Non-I/O cycle: ready at once, no request
        set_cycle(1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        check_val("nonio_ready1", bus.Ready1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("nonio_ioreq", bus.IOREQ, 1'b0);
        end
        set_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        // I/O read, IODONE 5 cycles after IOACT
        set_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        #1;
        check_val("rd_ready1_start", bus.Ready1, 1'b0);
        tick();
        check_val("rd_ale",   bus.ALE,   1'b1);
        check_val("rd_ioreq", bus.IOREQ, 1'b1);
        check_val("rd_iowr",  bus.IOWR,  1'b0);
        bus.IOACT = 1'b1;
        tick();
        check_val("rd_ale_gone",   bus.ALE,   1'b0);
        check_val("rd_ioreq_gone", bus.IOREQ, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("rd_ready1_wait", bus.Ready1, 1'b0);
        end
        bus.IODONE = 1'b1;
        bus.IOACT  = 1'b0;
        tick();
        bus.IODONE = 1'b0;
        check_val("rd_ready1_done", bus.Ready1, 1'b1);
        check_val("rd_berr1_done",  bus.BERR1,  1'b0);
        tick();
        check_val("rd_ready1_hold", bus.Ready1, 1'b1);
        bus.BACT = 1'b0;
        tick();
        check_val("rd_ready1_clear", bus.Ready1, 1'b0);
        bus.IOCS = 1'b0;
        tick();

        // Posted write, then a read that waits in BUFW
        set_cycle(1'b1, 1'b1, 1'b0, 1'b1);
        tick();
        check_val("pw_ale",    bus.ALE,    1'b1);
        check_val("pw_iowr",   bus.IOWR,   1'b1);
        check_val("pw_ready1_early", bus.Ready1, 1'b0);
        tick();
        check_val("pw_ready1", bus.Ready1, 1'b1);
        check_val("pw_pwpend", bus.PWPEND, 1'b1);
        check_val("pw_ioreq_held", bus.IOREQ, 1'b1);
        bus.IOACT = 1'b1;
        set_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check_val("pw_ioreq_gone",  bus.IOREQ,  1'b0);
        check_val("pw_pwpend_hold", bus.PWPEND, 1'b1);
        set_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check_val("bufw_ale_0", bus.ALE,    1'b0);
        check_val("bufw_ready", bus.Ready1, 1'b0);
        tick();
        check_val("bufw_ale_1", bus.ALE, 1'b0);
        bus.IODONE = 1'b1;
        bus.IOBERR = 1'b1;
        bus.IOACT  = 1'b0;
        tick();
        bus.IODONE = 1'b0;
        bus.IOBERR = 1'b0;
        check_val("bufw_pwpend_clr", bus.PWPEND, 1'b0);
        check_val("bufw_ale_same",   bus.ALE,    1'b0);
        check_val("bufw_berr1",      bus.BERR1,  1'b0);
        tick();
        check_val("bufw_launch_ale",   bus.ALE,   1'b1);
        check_val("bufw_launch_ioreq", bus.IOREQ, 1'b1);
        check_val("bufw_launch_iowr",  bus.IOWR,  1'b0);

        // That read completes with IOBERR=1
        bus.IOACT = 1'b1;
        tick();
        bus.IODONE = 1'b1;
        bus.IOBERR = 1'b1;
        bus.IOACT  = 1'b0;
        tick();
        bus.IODONE = 1'b0;
        bus.IOBERR = 1'b0;
        check_val("err_berr1",  bus.BERR1,  1'b1);
        check_val("err_ready1", bus.Ready1, 1'b0);
        tick();
        check_val("err_berr1_hold", bus.BERR1, 1'b1);
        bus.BACT = 1'b0;
        tick();
        check_val("err_berr1_clear", bus.BERR1, 1'b0);
        bus.IOCS = 1'b0;
        tick();

        // Timeout: no IOACT, no IODONE
        set_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        check_val("to_ioreq_wait", bus.IOREQ, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        check_val("to_berr1_early", bus.BERR1, 1'b0);
        check_val("to_ioreq_early", bus.IOREQ, 1'b1);
        tick();
        check_val("to_berr1",  bus.BERR1,  1'b1);
        check_val("to_ioreq",  bus.IOREQ,  1'b0);
        check_val("to_ready1", bus.Ready1, 1'b0);
        bus.IODONE = 1'b1;
        tick();
        bus.IODONE = 1'b0;
        check_val("late_berr1",  bus.BERR1,  1'b1);
        check_val("late_ready1", bus.Ready1, 1'b0);
        check_val("late_ioreq",  bus.IOREQ,  1'b0);
        bus.BACT = 1'b0;
        tick();
        check_val("to_berr1_clear", bus.BERR1, 1'b0);
        tick();

        // BACT falls during WAIT: completion returns straight to IDLE
        set_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        bus.IOACT = 1'b1;
        tick();
        bus.BACT = 1'b0;
        tick();
        tick();
        bus.IODONE = 1'b1;
        bus.IOACT  = 1'b0;
        tick();
        bus.IODONE = 1'b0;
        check_val("abort_ready1", bus.Ready1, 1'b0);
        check_val("abort_berr1",  bus.BERR1,  1'b0);
        set_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_val("abort_relaunch_ale", bus.ALE,  1'b1);
        check_val("abort_relaunch_wr",  bus.IOWR, 1'b1);
        tick();
        check_val("rstw_ioreq", bus.IOREQ, 1'b1);

        // Asynchronous reset in WAIT
        #3;
        rst_n = 1'b0;
        #1;
        check_val("arst_ioreq",  bus.IOREQ,  1'b0);
        check_val("arst_iowr",   bus.IOWR,   1'b0);
        check_val("arst_ready1", bus.Ready1, 1'b0);
        check_val("arst_berr1",  bus.BERR1,  1'b0);
        #2;
        set_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        tick();
        bus.IODONE = 1'b1;
        tick();
        bus.IODONE = 1'b0;
        check_val("arst_stray_ready1", bus.Ready1, 1'b0);
        set_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        check_val("arst_idle_launch", bus.ALE, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iobs.md
IOBS -- requirements
Module: iobs

Interface
REQ-001 Parameter: TIMEOUT, 8'd200, FCLK cycles an I/O cycle may wait for IODONE before a bus error is raised (legal range 1..255).
REQ-002 Port: FCLK  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port: nRST  in  1  asynchronous, active-low reset.
REQ-004 Port: BACT  in  1  CPU bus cycle active, registered by the FSB stage.
REQ-005 Port: IOCS  in  1  current cycle decodes to I/O space.
REQ-006 Port: IOPWCS  in  1  current address is eligible for a posted write.
REQ-007 Port: nWE  in  1  0 = write cycle.
REQ-008 Port: IOACT  in  1  I/O bus master has accepted the request and is busy.
REQ-009 Port: IODONE  in  1  one-cycle pulse: I/O cycle complete.
REQ-010 Port: IOBERR  in  1  error status; sampled only with IODONE.
REQ-011 Port: IOREQ  out  1  request to the I/O bus master.
REQ-012 Port: IOWR  out  1  1 = requested I/O cycle is a write.
REQ-013 Port: ALE  out  1  one-cycle pulse that latches address and data for the I/O master.
REQ-014 Port: Ready1  out  1  ready to the FSB stage.
REQ-015 Port: BERR1  out  1  bus error to the FSB stage.
REQ-016 Port: PWPEND  out  1  posted write outstanding.

Function
REQ-017 Ready1 SHALL equal ~IOCS | rdy_r (combinational), so non-I/O cycles are never stalled; rdy_r is a register.
REQ-018 The FSM SHALL have states IDLE, BUFW, LAUNCH, WAIT and DONE.
REQ-019 IDLE: if BACT & IOCS, go to BUFW when PWPEND | IOACT, otherwise go to LAUNCH.
REQ-020 BUFW: hold until ~PWPEND & ~IOACT, then go to LAUNCH; if BACT falls, go to IDLE.
REQ-021 LAUNCH (one cycle): pulse ALE, set IOREQ, set IOWR = ~nWE, clear the timeout counter.
REQ-022 LAUNCH, posted case (~nWE & IOPWCS): set PWPEND and rdy_r on the next edge and go to DONE.
REQ-023 LAUNCH, all other cases: go to WAIT.
REQ-024 IOREQ SHALL stay asserted until IOACT is sampled high, then deassert; the request is never withdrawn before IOACT unless a timeout occurs.
REQ-025 WAIT, on IODONE & ~IOBERR: set rdy_r and go to DONE.
REQ-026 WAIT, on IODONE & IOBERR: set BERR1 and go to DONE.
REQ-027 WAIT: increment the 8-bit counter each cycle; when it equals TIMEOUT, drop IOREQ, set BERR1 and go to DONE.
REQ-028 DONE: hold rdy_r and BERR1 until BACT is low, then clear both and go to IDLE.
REQ-029 If BACT falls while in WAIT, the FSM SHALL stay in WAIT until IODONE or timeout, then go directly to IDLE with no rdy_r or BERR1 pulse.
REQ-030 A posted write SHALL clear PWPEND on its IODONE; IOBERR on a posted write is discarded.
REQ-031 If IODONE clearing PWPEND coincides with a new I/O cycle in IDLE or BUFW, the new cycle SHALL launch on the following cycle, never the same one.
REQ-032 An IODONE arriving with no request outstanding (including after a timeout) SHALL be ignored.
REQ-033 rdy_r and BERR1 SHALL never be high simultaneously.

Reset
REQ-034 While nRST is low: state IDLE, counter 0, and IOREQ, IOWR, ALE, rdy_r, BERR1 and PWPEND all 0 (Ready1 therefore = ~IOCS).
REQ-035 Reset mid-cycle SHALL abandon any outstanding request and any posted write with no further outputs.

Structure
REQ-036 The state enum and the TIMEOUT default SHALL live in the shared package.
REQ-037 The timeout counter SHALL be one sub-module, iobs_wdt: inputs clear and enable, output expired.

Verification
REQ-038 I/O read, IODONE 5 cycles after IOACT, IOBERR=0: ALE 1 cycle, IOREQ drops after IOACT, Ready1 rises 1 cycle after IODONE, clears after BACT falls.
REQ-039 Posted write (nWE=0, IOPWCS=1): Ready1 2 cycles after BACT&IOCS, PWPEND=1 until IODONE; a following I/O read sits in BUFW and launches the cycle after PWPEND clears.
REQ-040 No IODONE, TIMEOUT=8: BERR1 asserted 8 cycles into WAIT, IOREQ 0, Ready1 stays 0; a late IODONE causes no change.
REQ-041 IODONE with IOBERR=1 on a read: BERR1=1 and Ready1=0 until BACT falls.
REQ-042 Non-I/O cycle (IOCS=0): Ready1=1 immediately and IOREQ never asserts.
REQ-043 nRST pulsed low in WAIT: all outputs 0 asynchronously; FSM in IDLE after release.
